// File: rtl/gelu_requant_pkg.sv
// gelu_requant_pkg: shared widths and the rounding/saturation helpers for gelu_requant
package gelu_requant_pkg;
  localparam int PROD_W = 65;
  localparam int SAT_W = 8;
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (SAT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);
  function automatic logic signed [PROD_W-1:0] rshift_round(input logic signed [PROD_W-1:0] p, input logic [5:0] sh);
    logic signed [PROD_W-1:0] b;
    b = (sh == 6'd0) ? '0 : PROD_W'(1) << (sh - 6'd1);
    return (p + b) >>> sh;
  endfunction
  function automatic logic [SAT_W-1:0] sat(input logic signed [PROD_W-1:0] r);
    return (r > SAT_MAX) ? SAT_W'(SAT_MAX) : (r < SAT_MIN) ? SAT_W'(SAT_MIN) : SAT_W'(r);
  endfunction
endpackage

// File: rtl/gelu_requant_if.sv
// gelu_requant_if: packed int8 output stream with valid/ready handshake
interface gelu_requant_if #(parameter int PACK = 4, parameter int O_W = 8) ();
  logic valid;
  logic ready;
  logic [PACK*O_W-1:0] data;
  logic [PACK-1:0] keep;
  logic last;
  modport master(output valid, data, keep, last, input ready);
  modport slave(input valid, data, keep, last, output ready);
endinterface

// File: rtl/gelu_requant_sync_fifo.sv
// sync_fifo: register-based FIFO with registered head and occupancy count
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [W-1:0] wdata,
  input  logic pop,
  output logic valid,
  output logic [W-1:0] rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic do_pop;
  always_comb begin
    do_pop = pop && (count_q != '0);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = wdata;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  assign valid = count_q != '0;
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/gelu_requant.sv
// gelu_requant: requantize GELU output to packed int8 words; GELU_REQUANT_SAT_CNT_EN adds a saturation counter
module gelu_requant
  import gelu_requant_pkg::*;
#(
  parameter int D_W = 32,
  parameter int M_W = 32,
  parameter int O_W = 8,
  parameter int PACK = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_en,
  input  logic in_valid,
  input  logic [D_W-1:0] in_data,
  input  logic in_last,
  input  logic [M_W-1:0] mult,
  input  logic [5:0] shift,
  output logic stall,
`ifdef GELU_REQUANT_SAT_CNT_EN
  input  logic sat_clr,
  output logic [15:0] sat_count,
`endif
  gelu_requant_if.master out_if
);
  localparam int LW = $clog2(PACK);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 1 + PACK + PACK*O_W;
  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic signed [PROD_W-1:0] s1_p_q, s1_p_d, r;
  logic [5:0] s1_sh_q, s1_sh_d;
  logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [O_W-1:0] s2_v_q, s2_v_d;
  logic [LW-1:0] lane_q, lane_d;
  logic [PACK*O_W-1:0] word_q, word_d, cur;
  logic [PACK-1:0] keep_c;
  logic push;
  logic [CW-1:0] f_count;
  always_comb begin
    s1_valid_d = in_valid && in_en;
    s1_last_d = in_last;
    s1_sh_d = shift;
    s1_p_d = $signed({{(PROD_W-D_W){in_data[D_W-1]}}, in_data}) * $signed({{(PROD_W-M_W){1'b0}}, mult});
    r = rshift_round(s1_p_q, s1_sh_q);
    s2_valid_d = s1_valid_q;
    s2_last_d = s1_last_q;
    s2_v_d = sat(r);
    cur = word_q;
    cur[lane_q*O_W +: O_W] = s2_v_q;
    keep_c = '0;
    for (int i = 0; i < PACK; i++) keep_c[i] = (i <= int'(lane_q));
    push = s2_valid_q && (lane_q == LW'(PACK-1) || s2_last_q);
    word_d = !s2_valid_q ? word_q : push ? '0 : cur;
    lane_d = !s2_valid_q ? lane_q : push ? '0 : lane_q + LW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_sh_q <= '0;
      s1_p_q <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_v_q <= '0;
      lane_q <= '0;
      word_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q <= s1_last_d;
      s1_sh_q <= s1_sh_d;
      s1_p_q <= s1_p_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q <= s2_last_d;
      s2_v_q <= s2_v_d;
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end
  sync_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .wdata({s2_last_q, keep_c, cur}),
    .pop(out_if.ready),
    .valid(out_if.valid),
    .rdata({out_if.last, out_if.keep, out_if.data}),
    .count(f_count)
  );
  // Two words can still be in flight in S1/S2 once stall is seen, hence the margin of 2.
  assign stall = f_count >= CW'(FIFO_DEPTH-2);
`ifdef GELU_REQUANT_SAT_CNT_EN
  logic [15:0] sat_q, sat_d;
  logic clip;
  always_comb begin
    clip = s1_valid_q && ((r > SAT_MAX) || (r < SAT_MIN));
    sat_d = sat_clr ? '0 : (clip && sat_q != 16'hFFFF) ? sat_q + 16'd1 : sat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) sat_q <= '0;
    else sat_q <= sat_d;
  end
  assign sat_count = sat_q;
`endif
endmodule

// File: tb/tb_gelu_requant.sv
// tb_gelu_requant: directed self-checking bench for gelu_requant
module tb_gelu_requant;
  logic clk = 0;
  logic rst, in_en, in_valid, in_last;
  logic [31:0] in_data, mult;
  logic [5:0] shift;
  logic stall;
`ifdef GELU_REQUANT_SAT_CNT_EN
  logic sat_clr;
  logic [15:0] sat_count;
`endif
  int checks = 0;
  int errors = 0;
  int n;
  logic [36:0] w;
  logic [36:0] q[$];
  gelu_requant_if #(.PACK(4), .O_W(8)) out_if ();
  gelu_requant dut (
    .clk(clk),
    .rst(rst),
    .in_en(in_en),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .mult(mult),
    .shift(shift),
    .stall(stall),
`ifdef GELU_REQUANT_SAT_CNT_EN
    .sat_clr(sat_clr),
    .sat_count(sat_count),
`endif
    .out_if(out_if)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst && out_if.valid && out_if.ready) q.push_back({out_if.last, out_if.keep, out_if.data});
    if (!rst && dut.u_fifo.push && dut.u_fifo.count_q == 4'd8 && !dut.u_fifo.do_pop) begin
      errors++;
      $error("FAIL fifo_overflow observed=push_at_full expected=no_push");
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    in_valid = 1; in_en = 1; in_data = d; in_last = l;
    tick();
    in_valid = 0; in_en = 0; in_last = 0;
  endtask
  task automatic get_word(input string tag, output logic [36:0] wo);
    int t = 0;
    while (q.size() == 0 && t < 200) begin tick(); t++; end
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout observed=no_word expected=word", tag);
      wo = 'x;
    end else wo = q.pop_front();
  endtask
  task automatic stream(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      in_valid = n < 12;
      in_en = !stall && n < 12;
      in_data = n;
      in_last = 1;
      @(posedge clk);
      if (in_valid && in_en) n++;
      #1;
    end
    in_valid = 0; in_en = 0; in_last = 0;
  endtask
  initial begin
    rst = 1; in_en = 0; in_valid = 0; in_last = 0; in_data = 0; mult = 5; shift = 2;
    out_if.ready = 1;
`ifdef GELU_REQUANT_SAT_CNT_EN
    sat_clr = 0;
`endif
    tick(); tick();
    rst = 0;
    chk("rst_valid", out_if.valid, 0);
    chk("rst_data", out_if.data, 0);
    chk("rst_keep", out_if.keep, 0);
    chk("rst_last", out_if.last, 0);
    chk("rst_stall", stall, 0);
`ifdef GELU_REQUANT_SAT_CNT_EN
    chk("rst_sat_count", sat_count, 0);
`endif
    send(10, 0); send(-10, 0); send(-11, 0); send(0, 1);
    get_word("basic", w);
    chk("basic_word", w, {1'b1, 4'hF, 32'h00F2F40D});
    mult = 3; shift = 2;
    send(1000, 0); send(-1000, 1);
    get_word("sat", w);
    chk("sat_word", w, {1'b1, 4'h3, 32'h0000807F});
`ifdef GELU_REQUANT_SAT_CNT_EN
    chk("sat_count", sat_count, 2);
    sat_clr = 1; tick(); sat_clr = 0;
    chk("sat_clr", sat_count, 0);
`endif
    mult = 1; shift = 0;
    for (int i = 0; i < 6; i++) send(1, i == 5);
    get_word("part0", w);
    chk("part_word0", w, {1'b0, 4'hF, 32'h01010101});
    get_word("part1", w);
    chk("part_word1", w, {1'b1, 4'h3, 32'h00000101});
    in_valid = 1; in_en = 1; in_data = 2; in_last = 0; tick();
    in_en = 0; in_data = 3; in_last = 1; tick(); tick(); tick();
    in_en = 1; tick();
    in_valid = 0; in_en = 0; in_last = 0;
    get_word("frozen", w);
    chk("frozen_word", w, {1'b1, 4'h3, 32'h00000302});
    repeat (10) tick();
    chk("frozen_no_extra", q.size(), 0);
    out_if.ready = 0; n = 0;
    stream(30);
    chk("bp_accepted", n, 8);
    chk("bp_stall", stall, 1);
    chk("bp_fifo_full", dut.u_fifo.count_q, 8);
    chk("bp_valid", out_if.valid, 1);
    out_if.ready = 1;
    stream(40);
    chk("bp_total", n, 12);
    for (int k = 0; k < 12; k++) begin
      get_word("bp", w);
      chk($sformatf("bp_word%0d", k), w, {1'b1, 4'h1, 32'(k)});
    end
    repeat (5) tick();
    chk("bp_no_extra", q.size(), 0);
    send(1, 0); send(2, 0); send(3, 0);
    repeat (3) tick();
    rst = 1; tick(); rst = 0;
    chk("mid_rst_valid", out_if.valid, 0);
    chk("mid_rst_data", out_if.data, 0);
    chk("mid_rst_keep", out_if.keep, 0);
    chk("mid_rst_last", out_if.last, 0);
    chk("mid_rst_stall", stall, 0);
    send(5, 1);
    get_word("after_rst", w);
    chk("after_rst_word", w, {1'b1, 4'h1, 32'h00000005});
    repeat (5) tick();
    chk("after_rst_no_extra", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
